// File: rtl/uart_fifo.sv
// Bus-attached UART with TX/RX FIFOs, programmable divisor, framing control and sticky errors.
// Register side effects act on the first edge of a bus call. A full FIFO drops new pushes.

module uart_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         full_o,
    output logic [8:0]   count_o
);
    // Synchronous FIFO with a combinational head. Status is taken before the edge.
    // A push to a full FIFO is dropped, even when a pop happens on the same edge.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = 9'(cnt_q);

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: ;
            endcase
        end
    end
endmodule

module uart_fifo #(
    parameter int   CLK_FREQ      = 50_000_000,
    parameter int   UART_BPS      = 115200,
    parameter int   DATA_BITS     = 8,
    parameter int   FIFO_DEPTH    = 16,
    parameter int   ADDR_W        = 16,
    parameter logic IO_CTRL_WRITE = 1'b1,
    parameter logic IO_CTRL_READ  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EN,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [15:0]       data,
    input  logic              ctrl,
    input  logic              uart_rxd,
    output logic              uart_txd,
    output logic              int_uart,
    output logic [7:0]        int_data
);
    // Bus side: four word registers. TX starts one clock after a DATA write.
    // RX pushes at the stop-bit sample. Both frames latch DIV and format at start.
    localparam logic [15:0] BAUD_RST = 16'(CLK_FREQ / UART_BPS - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP, TX_STOP2} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

    logic        rd_call, wr_call, rd_call_q, wr_call_q, rd_stb, wr_stb;
    logic [1:0]  reg_sel;
    logic [15:0] rd_dat;
    logic [5:0]  ctrl_q;
    logic [15:0] baud_q;
    logic        ovr_q, frm_q, par_q;
    logic        unused_addr;

    logic [DATA_BITS-1:0] tx_head, rx_head;
    logic                 tx_empty, tx_full, rx_empty, rx_full, tx_pop, rx_push;
    logic [8:0]           rx_count, unused_tx_count;

    tx_state_t            tx_state_q, tx_state_d;
    logic [15:0]          tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic                 tx_pbit_q, tx_pbit_d, tx_pen_q, tx_pen_d, tx_stop2_q, tx_stop2_d;
    logic                 txd_q, txd_d, tx_load, tx_bit_end;

    rx_state_t            rx_state_q, rx_state_d;
    logic [1:0]           rx_sync_q;
    logic                 rx_prev_q, rxd_s, rx_fall;
    logic [15:0]          rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic                 rx_pbit_q, rx_pbit_d, rx_pen_q, rx_pen_d, rx_podd_q, rx_podd_d;
    logic                 rx_bit_end, ovr_set, frm_set, par_set, w1c;

    assign unused_addr = ^addr[ADDR_W-1:2];
    assign reg_sel     = addr[1:0];
    assign rd_call     = EN && (ctrl == IO_CTRL_READ);
    assign wr_call     = EN && (ctrl == IO_CTRL_WRITE);
    assign rd_stb      = rd_call && !rd_call_q;
    assign wr_stb      = wr_call && !wr_call_q;
    assign w1c         = wr_stb && (reg_sel == 2'd1);

    uart_fifo_buf #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n),
        .push_i(wr_stb && (reg_sel == 2'd0)), .push_dat_i(data[DATA_BITS-1:0]),
        .pop_i(tx_pop), .head_o(tx_head), .empty_o(tx_empty), .full_o(tx_full),
        .count_o(unused_tx_count)
    );

    uart_fifo_buf #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n),
        .push_i(rx_push), .push_dat_i(rx_sh_q),
        .pop_i(rd_stb && (reg_sel == 2'd0)), .head_o(rx_head), .empty_o(rx_empty),
        .full_o(rx_full), .count_o(rx_count)
    );

    always_comb begin
        rd_dat = '0;
        case (reg_sel)
            2'd0: rd_dat = rx_empty ? 16'd0 : 16'(rx_head);
            2'd1: rd_dat = {rx_count[7:0], par_q, frm_q, ovr_q, (tx_state_q != TX_IDLE),
                            tx_full, tx_empty, rx_full, !rx_empty};
            2'd2: rd_dat = {10'd0, ctrl_q};
            default: rd_dat = baud_q;
        endcase
    end

    assign data     = rd_call ? rd_dat : 16'hzzzz;
    assign int_uart = ctrl_q[5] && !rx_empty;
    assign int_data = rx_empty ? 8'd0 : 8'(rx_head);
    assign uart_txd = txd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_call_q <= 1'b0;
            wr_call_q <= 1'b0;
            ctrl_q    <= 6'h03;
            baud_q    <= BAUD_RST;
            ovr_q     <= 1'b0;
            frm_q     <= 1'b0;
            par_q     <= 1'b0;
        end else begin
            rd_call_q <= rd_call;
            wr_call_q <= wr_call;
            if (wr_stb && (reg_sel == 2'd2)) ctrl_q <= data[5:0];
            if (wr_stb && (reg_sel == 2'd3)) baud_q <= (data < 16'd3) ? 16'd3 : data;
            // A set on the same edge as a W1C wins.
            ovr_q <= (ovr_q && !(w1c && data[5])) || ovr_set;
            frm_q <= (frm_q && !(w1c && data[6])) || frm_set;
            par_q <= (par_q && !(w1c && data[7])) || par_set;
        end
    end

    assign tx_bit_end = (tx_cnt_q == tx_div_q);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 16'd1;
        tx_div_d   = tx_div_q;
        tx_sh_d    = tx_sh_q;
        tx_bit_d   = tx_bit_q;
        tx_pbit_d  = tx_pbit_q;
        tx_pen_d   = tx_pen_q;
        tx_stop2_d = tx_stop2_q;
        txd_d      = txd_q;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                txd_d    = 1'b1;
                tx_load  = ctrl_q[0] && !tx_empty;
            end
            TX_START: if (tx_bit_end) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_state_d = TX_DATA;
                txd_d      = tx_sh_q[0];
            end
            TX_DATA: if (tx_bit_end) begin
                tx_cnt_d = '0;
                if (tx_bit_q == LAST_BIT) begin
                    tx_state_d = tx_pen_q ? TX_PAR : TX_STOP;
                    txd_d      = tx_pen_q ? tx_pbit_q : 1'b1;
                end else begin
                    tx_bit_d = tx_bit_q + 3'd1;
                    tx_sh_d  = tx_sh_q >> 1;
                    txd_d    = tx_sh_q[1];
                end
            end
            TX_PAR: if (tx_bit_end) begin
                tx_cnt_d   = '0;
                tx_state_d = TX_STOP;
                txd_d      = 1'b1;
            end
            TX_STOP: if (tx_bit_end) begin
                tx_cnt_d   = '0;
                tx_state_d = tx_stop2_q ? TX_STOP2 : TX_IDLE;
                tx_load    = !tx_stop2_q && ctrl_q[0] && !tx_empty;
            end
            default: if (tx_bit_end) begin
                tx_cnt_d   = '0;
                tx_state_d = TX_IDLE;
                tx_load    = ctrl_q[0] && !tx_empty;
            end
        endcase
        // Chaining straight from the stop bit keeps back-to-back frames gapless.
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_div_d   = baud_q;
            tx_sh_d    = tx_head;
            tx_pen_d   = ctrl_q[3] ^ ctrl_q[2];
            tx_pbit_d  = (ctrl_q[3:2] == 2'b01) ? ~^tx_head : ^tx_head;
            tx_stop2_d = ctrl_q[4];
            txd_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= BAUD_RST;
            tx_sh_q    <= '0;
            tx_bit_q   <= '0;
            tx_pbit_q  <= 1'b0;
            tx_pen_q   <= 1'b0;
            tx_stop2_q <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_sh_q    <= tx_sh_d;
            tx_bit_q   <= tx_bit_d;
            tx_pbit_q  <= tx_pbit_d;
            tx_pen_q   <= tx_pen_d;
            tx_stop2_q <= tx_stop2_d;
            txd_q      <= txd_d;
        end
    end

    assign rxd_s      = rx_sync_q[1];
    assign rx_fall    = rx_prev_q && !rxd_s;
    assign rx_bit_end = (rx_cnt_q == rx_div_q);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_div_d   = rx_div_q;
        rx_sh_d    = rx_sh_q;
        rx_bit_d   = rx_bit_q;
        rx_pbit_d  = rx_pbit_q;
        rx_pen_d   = rx_pen_q;
        rx_podd_d  = rx_podd_q;
        rx_push    = 1'b0;
        ovr_set    = 1'b0;
        frm_set    = 1'b0;
        par_set    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (ctrl_q[1] && rx_fall) begin
                    rx_state_d = RX_START;
                    rx_div_d   = baud_q;
                    rx_pen_d   = ctrl_q[3] ^ ctrl_q[2];
                    rx_podd_d  = (ctrl_q[3:2] == 2'b01);
                end
            end
            RX_START: if (rx_cnt_q == (rx_div_q >> 1)) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rxd_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_bit_end) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rxd_s, rx_sh_q[DATA_BITS-1:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == LAST_BIT) rx_state_d = rx_pen_q ? RX_PAR : RX_STOP;
            end
            RX_PAR: if (rx_bit_end) begin
                rx_cnt_d   = '0;
                rx_pbit_d  = rxd_s;
                rx_state_d = RX_STOP;
            end
            default: if (rx_bit_end) begin
                rx_cnt_d   = '0;
                rx_state_d = RX_IDLE;
                if (!rxd_s) begin
                    frm_set = 1'b1;
                end else begin
                    rx_push = 1'b1;
                    ovr_set = rx_full;
                    par_set = rx_pen_q &&
                              (rx_pbit_q != (rx_podd_q ? ~^rx_sh_q : ^rx_sh_q));
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= BAUD_RST;
            rx_sh_q    <= '0;
            rx_bit_q   <= '0;
            rx_pbit_q  <= 1'b0;
            rx_pen_q   <= 1'b0;
            rx_podd_q  <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], uart_rxd};
            rx_prev_q  <= rxd_s;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_sh_q    <= rx_sh_d;
            rx_bit_q   <= rx_bit_d;
            rx_pbit_q  <= rx_pbit_d;
            rx_pen_q   <= rx_pen_d;
            rx_podd_q  <= rx_podd_d;
        end
    end
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: bus-level model of the RX FIFO and sticky flags, plus literal checks.
module tb_uart_fifo;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        EN = 1'b0;
    logic        ctrl = 1'b0;
    logic        uart_rxd = 1'b1;
    logic [15:0] addr = '0;
    logic [15:0] tb_dat = '0;
    logic        tb_drv = 1'b0;
    wire  [15:0] data;
    wire         uart_txd, int_uart;
    wire  [7:0]  int_data;

    assign data = tb_drv ? tb_dat : 16'hzzzz;

    uart_fifo #(.CLK_FREQ(50_000_000), .UART_BPS(115200), .DATA_BITS(8),
                .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .EN(EN), .addr(addr), .data(data), .ctrl(ctrl),
        .uart_rxd(uart_rxd), .uart_txd(uart_txd), .int_uart(int_uart), .int_data(int_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: what software should see.
    logic [7:0]  rx_q[$];
    logic        m_ovr = 1'b0, m_frm = 1'b0, m_par = 1'b0;
    logic [5:0]  m_ctrl = 6'h03;
    logic [15:0] m_baud = 16'd433;
    bit          chk_en = 1'b0;
    bit          tx_idle_m = 1'b1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_status(input bit tx_empty, input bit tx_full, input bit busy);
        int n;
        n = rx_q.size();
        return {8'(n), m_par, m_frm, m_ovr, busy, tx_full, tx_empty, (n == DEPTH), (n != 0)};
    endfunction

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("int_uart", 16'(int_uart), 16'(m_ctrl[5] && (rx_q.size() != 0)));
            check("int_data", 16'(int_data), (rx_q.size() != 0) ? 16'(rx_q[0]) : 16'd0);
            if (tx_idle_m) check("txd_idle", 16'(uart_txd), 16'd1);
        end
    end

    task automatic bus_wr(input logic [1:0] a, input logic [15:0] v);
        @(negedge clk);
        EN = 1'b1; ctrl = 1'b1; addr = {14'd0, a}; tb_dat = v; tb_drv = 1'b1;
        @(posedge clk);
        #1;
        EN = 1'b0; tb_drv = 1'b0;
        case (a)
            2'd1: begin
                if (v[5]) m_ovr = 1'b0;
                if (v[6]) m_frm = 1'b0;
                if (v[7]) m_par = 1'b0;
            end
            2'd2: m_ctrl = v[5:0];
            2'd3: m_baud = (v < 16'd3) ? 16'd3 : v;
            default: ;
        endcase
        @(posedge clk);
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [15:0] v);
        @(negedge clk);
        EN = 1'b1; ctrl = 1'b0; addr = {14'd0, a};
        #1;
        v = data;
        @(posedge clk);
        #1;
        EN = 1'b0;
        if (a == 2'd0 && rx_q.size() != 0) void'(rx_q.pop_front());
        @(posedge clk);
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [15:0] exp, input string name);
        logic [15:0] v;
        bus_rd(a, v);
        check(name, v, exp);
    endtask

    task automatic send_rx(input logic [7:0] ch, input bit bad_par, input bit bad_stop);
        int  bp;
        bit  pen, p;
        bp  = int'(m_baud) + 1;
        pen = (m_ctrl[3:2] == 2'b01) || (m_ctrl[3:2] == 2'b10);
        p   = (m_ctrl[3:2] == 2'b10) ? ^ch : ~^ch;
        chk_en = 1'b0;
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (bp) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = ch[i];
            repeat (bp) @(negedge clk);
        end
        if (pen) begin
            uart_rxd = p ^ bad_par;
            repeat (bp) @(negedge clk);
        end
        uart_rxd = !bad_stop;
        repeat (bp) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (4) @(negedge clk);
        if (bad_stop) m_frm = 1'b1;
        else begin
            if (pen && bad_par) m_par = 1'b1;
            if (rx_q.size() == DEPTH) m_ovr = 1'b1;
            else rx_q.push_back(ch);
        end
        @(posedge clk);
        #1 chk_en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ch;
        logic       e;
        int         b;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk_en = 1'b1;
        check("rst_txd", 16'(uart_txd), 16'd1);
        check("rst_int_uart", 16'(int_uart), 16'd0);
        check("rst_int_data", 16'(int_data), 16'd0);
        rd_chk(2'd1, 16'h0004, "rst_status");
        rd_chk(2'd2, 16'h0003, "rst_ctrl");
        rd_chk(2'd3, 16'd433, "rst_baud");
        rd_chk(2'd0, 16'h0000, "rst_data_empty");

        bus_wr(2'd3, 16'd1);
        rd_chk(2'd3, 16'd3, "baud_clamp");
        bus_wr(2'd3, 16'd9);
        rd_chk(2'd3, m_baud, "baud_9");

        // Two back-to-back frames, 10 clocks per bit, start bit right after the write.
        tx_idle_m = 1'b0;
        bus_wr(2'd0, 16'h0055);
        fork
            bus_wr(2'd0, 16'h00A3);
            for (int k = 0; k < 210; k++) begin
                @(negedge clk);
                if (k < 200) begin
                    ch = (k < 100) ? 8'h55 : 8'hA3;
                    b  = (k % 100) / 10;
                    e  = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : ch[b-1];
                end else begin
                    e = 1'b1;
                end
                check("txd_frame", 16'(uart_txd), 16'(e));
            end
        join
        tx_idle_m = 1'b1;
        rd_chk(2'd1, exp_status(1'b1, 1'b0, 1'b0), "tx_done_status");

        // Even parity, corrupted parity bit: character kept, parity_err set.
        bus_wr(2'd2, 16'h000B);
        send_rx(8'h37, 1'b1, 1'b0);
        rd_chk(2'd1, 16'h0185, "par_err_status");
        bus_wr(2'd1, 16'h0080);
        rd_chk(2'd1, exp_status(1'b1, 1'b0, 1'b0), "par_w1c_status");
        rd_chk(2'd0, 16'h0037, "par_data");

        bus_wr(2'd2, 16'h0007);
        send_rx(8'hC4, 1'b0, 1'b0);
        rd_chk(2'd1, exp_status(1'b1, 1'b0, 1'b0), "odd_par_status");
        rd_chk(2'd0, 16'h00C4, "odd_par_data");

        // Overflow a 4-deep RX FIFO with interrupts enabled.
        bus_wr(2'd2, 16'h0023);
        for (int i = 1; i <= 5; i++) send_rx(8'(8'h11 * i), 1'b0, 1'b0);
        rd_chk(2'd1, 16'h0427, "rx_full_status");
        rd_chk(2'd1, exp_status(1'b1, 1'b0, 1'b0), "rx_full_model");
        check("int_uart_full", 16'(int_uart), 16'd1);
        for (int i = 1; i <= 4; i++) rd_chk(2'd0, 16'(8'(8'h11 * i)), "rx_order");
        rd_chk(2'd0, 16'h0000, "rx_drained");
        bus_wr(2'd1, 16'h00E0);
        rd_chk(2'd1, 16'h0004, "ovr_w1c");

        // Short glitch rejected, then a frame with a low stop bit.
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (20) @(negedge clk);
        rd_chk(2'd1, 16'h0004, "glitch_status");
        send_rx(8'h5A, 1'b0, 1'b1);
        rd_chk(2'd1, 16'h0044, "frame_err_status");
        rd_chk(2'd0, 16'h0000, "frame_no_push");
        bus_wr(2'd1, 16'h0040);

        // Fill TX, overflow it, then reset mid-frame.
        tx_idle_m = 1'b0;
        bus_wr(2'd0, 16'h0000);
        for (int i = 1; i <= 5; i++) bus_wr(2'd0, 16'(i));
        rd_chk(2'd1, 16'h0018, "tx_full_status");
        check("txd_mid_frame", 16'(uart_txd), 16'd0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("rst_async_txd", 16'(uart_txd), 16'd1);
        EN = 1'b1; ctrl = 1'b0; addr = 16'd1;
        #1 check("rst_status_comb", data, 16'h0004);
        EN = 1'b0;
        rx_q.delete();
        m_ovr = 1'b0; m_frm = 1'b0; m_par = 1'b0;
        m_ctrl = 6'h03; m_baud = 16'd433;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tx_idle_m = 1'b1;
        rd_chk(2'd1, 16'h0004, "post_rst_status");
        rd_chk(2'd2, 16'h0003, "post_rst_ctrl");
        rd_chk(2'd3, 16'd433, "post_rst_baud");
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
